// File: rtl/spim_wb.sv
// spim_wb: Wishbone slave SPI master (mode 0, MSB first) for the SD-card SPI bus.
// One-entry TX holding register lets back-to-back bytes run without idle cycles.
module spim_wb (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        sd_ss,
    output logic        sd_sck,
    output logic        sd_mosi,
    input  logic        sd_miso
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

    state_e      state_q;
    logic [7:0]  div_q;
    logic        ss_q;
    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic [7:0]  rxdata_q;
    logic        rxv_q;
    logic        ovr_q;
    logic [7:0]  cnt_q;
    logic [2:0]  bitn_q;
    logic [7:0]  sh_q;
    logic        rxb_q;
    logic        sck_q;
    logic        mosi_q;
    logic        ack_q;
    logic [31:0] dat_q;

    logic        acc;
    logic [1:0]  reg_sel;
    logic        data_wr;
    logic        data_rd;
    logic        ctrl_wr;
    logic        status_wr;
    logic        byte_done;
    logic        consume;
    logic [31:0] rd_data;
    logic [3:0]  status;

    // Byte lanes and undecoded address bits are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:9]};

    assign acc       = wb_cyc_i & wb_stb_i & ~ack_q;
    assign reg_sel   = wb_adr_i[3:2];
    assign data_wr   = acc & wb_we_i & (reg_sel == 2'd0);
    assign data_rd   = acc & ~wb_we_i & (reg_sel == 2'd0);
    assign ctrl_wr   = acc & wb_we_i & (reg_sel == 2'd1);
    assign status_wr = acc & wb_we_i & (reg_sel == 2'd2);

    // Last falling edge of the byte.
    assign byte_done = (state_q == StHigh) && (cnt_q == 8'd0) && (bitn_q == 3'd7);
    // Engine takes the holding register this cycle (from idle or chained at byte end).
    assign consume   = hold_full_q && ((state_q == StIdle) || byte_done);

    assign status = {ovr_q, rxv_q, hold_full_q, state_q != StIdle};

    // Register read mux.
    always_comb begin
        rd_data = 32'd0;
        unique case (reg_sel)
            2'd0:    rd_data = {24'd0, rxdata_q};
            2'd1:    rd_data = {23'd0, ss_q, div_q};
            2'd2:    rd_data = {28'd0, status};
            default: rd_data = 32'd0;
        endcase
    end

    // Bus handshake: one-cycle ack and registered read data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            ack_q <= acc;
            if (acc) begin
                dat_q <= rd_data;
            end
        end
    end

    // Software-visible registers; writes are judged against pre-consumption state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_q       <= 8'hFF;
            ss_q        <= 1'b1;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            rxdata_q    <= 8'd0;
            rxv_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                div_q <= wb_dat_i[7:0];
                ss_q  <= wb_dat_i[8];
            end
            if (status_wr) begin
                ovr_q <= 1'b0;
            end
            if (data_wr) begin
                if (hold_full_q) begin
                    ovr_q <= 1'b1;
                end else begin
                    hold_q      <= wb_dat_i[7:0];
                    hold_full_q <= 1'b1;
                end
            end
            if (consume) begin
                hold_full_q <= 1'b0;
            end
            // Completion wins over a concurrent DATA read so the new byte is not lost.
            if (byte_done) begin
                rxdata_q <= {sh_q[6:0], rxb_q};
                rxv_q    <= 1'b1;
            end else if (data_rd) begin
                rxv_q <= 1'b0;
            end
        end
    end

    // Shift engine: LOW/HIGH half-periods of div+1 clocks each.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            bitn_q  <= 3'd0;
            sh_q    <= 8'd0;
            rxb_q   <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sck_q <= 1'b0;
                    if (hold_full_q) begin
                        sh_q    <= hold_q;
                        mosi_q  <= hold_q[7];
                        bitn_q  <= 3'd0;
                        cnt_q   <= div_q;
                        state_q <= StLow;
                    end
                end
                StLow: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        sck_q   <= 1'b1;
                        rxb_q   <= sd_miso;
                        cnt_q   <= div_q;
                        state_q <= StHigh;
                    end
                end
                StHigh: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        sck_q <= 1'b0;
                        sh_q  <= {sh_q[6:0], rxb_q};
                        if (bitn_q != 3'd7) begin
                            bitn_q  <= bitn_q + 3'd1;
                            mosi_q  <= sh_q[6];
                            cnt_q   <= div_q;
                            state_q <= StLow;
                        end else if (hold_full_q) begin
                            // Chain the pending byte with no idle cycle.
                            sh_q    <= hold_q;
                            mosi_q  <= hold_q[7];
                            bitn_q  <= 3'd0;
                            cnt_q   <= div_q;
                            state_q <= StLow;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign sd_ss    = ss_q;
    assign sd_sck   = sck_q;
    assign sd_mosi  = mosi_q;

endmodule
